alu_issue_seq: RTL and testbench
================================

# alu_issue_seq

Operand/issue sequencer directly upstream of `alu32`. Buffers ALU requests in a small in-order FIFO and drives `alu32`'s `a`/`b`/`op` from registers held stable for the whole evaluation interval, including the multi-cycle multiply. Captures `alu32.out` and returns it through a valid/ready response port. This lets the datapath issue ALU work without tracking multiply latency itself.

## Interface
- `WIDTH`, 32: operand/result width; must match `alu32`.
- `MULT_CYCLES`, 33: cycles operands are held for op `010` (multiply) before the result is sampled.
- `FIFO_DEPTH`, 4: request FIFO entries; power of two, at least 2.

Ports:
- `CLK`  in  1: single clock, rising edge.
- `RST`  in  1: reset, synchronous, active-high.
- `req_valid`  in  1: request present.
- `req_ready`  out  1: FIFO can accept; equals `!full`.
- `req_a`, `req_b`  in  WIDTH: operands.
- `req_op`  in  3: opcode. 000 add, 001 sub, 010 mul (low word), 011 xor, 100 and, 101 or, 110 slt, 111 nor.
- `alu_a`, `alu_b`  out  WIDTH: to `alu32.a`/`alu32.b`, registered.
- `alu_op`  out  3: to `alu32.op`, registered.
- `alu_out`  in  WIDTH: from `alu32.out`.
- `rsp_valid`  out  1: result available.
- `rsp_ready`  in  1: consumer accepts result.
- `rsp_data`  out  WIDTH: captured result.
- `rsp_op`  out  3: opcode of the returned result.
- `busy`  out  1: high when state is not IDLE or the FIFO is non-empty.

## Operation
- **FIFO**
  - Push on `req_valid && req_ready`. Pop is done only by the FSM.
  - Order is strictly in-order; there is no bypass.
  - `req_ready` depends only on the registered full flag. When the FIFO is full, a same-cycle pop does not enable a push.
- **FSM states**
  - **IDLE**: if the FIFO is non-empty, pop the head and load `alu_a`/`alu_b`/`alu_op`. Load `cnt` with `MULT_CYCLES-1` if op=010, otherwise 0. Go to EXEC. If the FIFO is empty, stay in IDLE.
  - **EXEC**: `alu_*` are frozen. If `cnt!=0`, decrement. If `cnt==0`, set `rsp_data<=alu_out`, `rsp_op<=alu_op`, `rsp_valid<=1`, and go to DONE.
  - **DONE**: hold `rsp_*` and `alu_*`. On `rsp_valid && rsp_ready`:
    - If the FIFO is non-empty, pop and load the next operation and go directly to EXEC, clearing `rsp_valid`.
    - Otherwise clear `rsp_valid` and go to IDLE.
- `alu_a`/`alu_b`/`alu_op` change only on a pop edge. In IDLE they retain their last values.
- `rsp_data` is stable while `rsp_valid` is high and `rsp_ready` is low.
- Arithmetic is performed entirely by `alu32`. This block performs no width conversion; mul returns the low WIDTH bits as delivered on `alu_out`.
- `cnt` width is `clog2(MULT_CYCLES)` bits; `cnt` never wraps.
- **Reset** (`RST` high at an edge):
  - State goes to IDLE; FIFO pointers and count go to 0.
  - `cnt`, `alu_a`, `alu_b`, `alu_op`, `rsp_data`, `rsp_op`, `rsp_valid` all go to 0.
  - Resulting outputs: `busy=0`, `req_ready=1`.
  - Reset mid-EXEC or mid-DONE discards the in-flight operation and all queued operations. No response is produced for them.
  - `RST` has priority over every push, pop and handshake in the same cycle.

## Timing
- Request accepted at edge k with the FSM in IDLE and the FIFO otherwise empty:
  - Pop at edge k+1.
  - Non-mul: capture at edge k+2, so `rsp_valid` is high from cycle k+2.
  - Mul: capture at edge k+1+`MULT_CYCLES`.
- Throughput for back-to-back non-mul with `rsp_ready=1`: one response every 2 cycles.
- Throughput for back-to-back mul: one response every `MULT_CYCLES`+1 cycles.
- Capacity with `rsp_ready` held low: `FIFO_DEPTH`+1 operations are accepted (one in DONE, the rest queued). After that `req_ready=0`.
- `alu_*` are held constant for at least the full EXEC interval. This is the stability contract the multiply path of `alu32` requires.
- `rsp_valid` never drops without a handshake, except on reset.

## Test plan
- **Reset, then add:** `RST` for 2 cycles, then add `a=5`, `b=3`. Required: `rsp_valid` rises exactly 2 cycles after acceptance, with `rsp_data=8` and `rsp_op=000`. `busy` returns to 0 after the handshake.
- **Sub and slt:** sub `3-5` returns `0xFFFFFFFE`. slt `a=3`, `b=5` returns 1. slt `a=5`, `b=3` returns 0. All are returned in issue order.
- **Multiply:** mul `7*6` returns 42 at `MULT_CYCLES`+1 cycles after acceptance. `alu_a`/`alu_b`/`alu_op` must not toggle during EXEC (checked every cycle).
- **Backpressure:** hold `rsp_ready=0` and drive 6 requests. Exactly 5 are accepted and the 6th sees `req_ready=0`. Then release `rsp_ready`. Required: 5 responses in order, one every 2 cycles.
- **Reset mid-mul:** assert `RST` on the 10th cycle of a mul with 2 operations queued. Required: on the next cycle `rsp_valid=0`, `busy=0`, `req_ready=1`, all `alu_*=0`. No response ever emerges for the flushed operations.
- **Simultaneous events:** push and response handshake in the same cycle while the FIFO holds 1 entry. Required: the head goes directly from DONE to EXEC, the new entry is queued, and no request is lost or duplicated.

Source files
------------

// File: rtl/alu_issue_seq.sv
// rtl/alu_issue_seq.sv - in-order ALU request FIFO and operand-hold issue sequencer for alu32
module alu_issue_seq #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 33,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [2:0]       req_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_out,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic [2:0]       rsp_op,
  output logic             busy
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = (MULT_CYCLES > 1) ? $clog2(MULT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] MUL_LOAD  = CNT_W'(MULT_CYCLES - 1);
  localparam logic [PTR_W:0]   DEPTH_CNT = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [2:0]       OP_MUL    = 3'b010;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state;
  logic [CNT_W-1:0] cnt;

  // Request storage; contents need no reset because pointers gate every read.
  logic [WIDTH-1:0] mem_a  [FIFO_DEPTH];
  logic [WIDTH-1:0] mem_b  [FIFO_DEPTH];
  logic [2:0]       mem_op [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   fifo_cnt;
  logic [PTR_W:0]   fifo_cnt_next;
  logic             full_q;
  logic             empty;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] head_a;
  logic [WIDTH-1:0] head_b;
  logic [2:0]       head_op;

  // Push is gated only by the registered full flag, so a pop while full frees no slot this cycle.
  assign req_ready = !full_q;
  assign push      = req_valid && !full_q;
  assign empty     = (fifo_cnt == '0);
  assign head_a    = mem_a[rd_ptr];
  assign head_b    = mem_b[rd_ptr];
  assign head_op   = mem_op[rd_ptr];
  assign busy      = (state != S_IDLE) || !empty;

  // Pop happens when the FSM is free to start the head entry: from IDLE, or on a DONE handshake.
  always_comb begin
    pop = 1'b0;
    if (!empty) begin
      if (state == S_IDLE)
        pop = 1'b1;
      else if (state == S_DONE && rsp_valid && rsp_ready)
        pop = 1'b1;
    end
  end

  // Occupancy after this cycle's push/pop.
  always_comb begin
    fifo_cnt_next = fifo_cnt;
    case ({push, pop})
      2'b10:   fifo_cnt_next = fifo_cnt + 1'b1;
      2'b01:   fifo_cnt_next = fifo_cnt - 1'b1;
      default: fifo_cnt_next = fifo_cnt;
    endcase
  end

  // Write accepted requests into the slot at the write pointer.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem_a[wr_ptr]  <= req_a;
      mem_b[wr_ptr]  <= req_b;
      mem_op[wr_ptr] <= req_op;
    end
  end

  // FIFO pointers, occupancy and registered full flag.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      full_q   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      fifo_cnt <= fifo_cnt_next;
      full_q   <= (fifo_cnt_next == DEPTH_CNT);
    end
  end

  // Issue FSM: operands only change on a pop, and are held through EXEC and DONE.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= S_IDLE;
      cnt       <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= '0;
      rsp_data  <= '0;
      rsp_op    <= '0;
      rsp_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pop) begin
            alu_a  <= head_a;
            alu_b  <= head_b;
            alu_op <= head_op;
            cnt    <= (head_op == OP_MUL) ? MUL_LOAD : '0;
            state  <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            rsp_data  <= alu_out;
            rsp_op    <= alu_op;
            rsp_valid <= 1'b1;
            state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (rsp_valid && rsp_ready) begin
            rsp_valid <= 1'b0;
            if (pop) begin
              alu_a  <= head_a;
              alu_b  <= head_b;
              alu_op <= head_op;
              cnt    <= (head_op == OP_MUL) ? MUL_LOAD : '0;
              state  <= S_EXEC;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_seq.sv
// tb/tb_alu_issue_seq.sv - directed self-checking bench for alu_issue_seq
module tb_alu_issue_seq;

  localparam int W  = 32;
  localparam int MC = 33;
  localparam int FD = 4;

  logic          CLK = 1'b0;
  logic          RST;
  logic          req_valid;
  logic          req_ready;
  logic [W-1:0]  req_a;
  logic [W-1:0]  req_b;
  logic [2:0]    req_op;
  logic [W-1:0]  alu_a;
  logic [W-1:0]  alu_b;
  logic [2:0]    alu_op;
  logic [W-1:0]  alu_out;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [W-1:0]  rsp_data;
  logic [2:0]    rsp_op;
  logic          busy;

  int checks = 0;
  int errors = 0;

  alu_issue_seq #(.WIDTH(W), .MULT_CYCLES(MC), .FIFO_DEPTH(FD)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_op    (req_op),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_op    (alu_op),
    .alu_out   (alu_out),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_op    (rsp_op),
    .busy      (busy)
  );

  always #5 CLK = ~CLK;

  // Stand-in for alu32.
  always_comb begin
    alu_out = '0;
    case (alu_op)
      3'b000: alu_out = alu_a + alu_b;
      3'b001: alu_out = alu_a - alu_b;
      3'b010: alu_out = alu_a * alu_b;
      3'b011: alu_out = alu_a ^ alu_b;
      3'b100: alu_out = alu_a & alu_b;
      3'b101: alu_out = alu_a | alu_b;
      3'b110: alu_out = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
      default: alu_out = ~(alu_a | alu_b);
    endcase
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic push1(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    chk("push_ready", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_a     = a;
    req_b     = b;
    req_op    = op;
    tick;
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string tag, input logic [31:0] data, input logic [2:0] op);
    int n;
    n = 0;
    while (!rsp_valid && n < 100) begin
      tick;
      n++;
    end
    chk({tag, "_valid"}, {31'd0, rsp_valid}, 32'd1);
    chk({tag, "_data"}, rsp_data, data);
    chk({tag, "_op"}, {29'd0, rsp_op}, {29'd0, op});
    tick;
  endtask

  initial begin
    int acc;
    int seen;
    RST = 1'b1; req_valid = 1'b0; req_a = '0; req_b = '0; req_op = '0; rsp_ready = 1'b0;
    tick;
    tick;
    RST = 1'b0;

    // Reset state
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_op", {29'd0, alu_op}, 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);

    // Add 5+3: response two cycles after acceptance
    push1(32'd5, 32'd3, 3'b000);
    chk("add_k_valid", {31'd0, rsp_valid}, 32'd0);
    chk("add_k_busy", {31'd0, busy}, 32'd1);
    tick;
    chk("add_k1_valid", {31'd0, rsp_valid}, 32'd0);
    chk("add_k1_alu_a", alu_a, 32'd5);
    chk("add_k1_alu_b", alu_b, 32'd3);
    tick;
    chk("add_k2_valid", {31'd0, rsp_valid}, 32'd1);
    chk("add_k2_data", rsp_data, 32'd8);
    chk("add_k2_op", {29'd0, rsp_op}, 32'd0);
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
    chk("add_hs_valid", {31'd0, rsp_valid}, 32'd0);
    chk("add_hs_busy", {31'd0, busy}, 32'd0);

    // Sub and slt, in issue order
    push1(32'd3, 32'd5, 3'b001);
    push1(32'd3, 32'd5, 3'b110);
    push1(32'd5, 32'd3, 3'b110);
    rsp_ready = 1'b1;
    wait_rsp("sub", 32'hFFFF_FFFE, 3'b001);
    wait_rsp("slt_lt", 32'd1, 3'b110);
    wait_rsp("slt_ge", 32'd0, 3'b110);
    rsp_ready = 1'b0;
    tick;
    chk("seq_busy", {31'd0, busy}, 32'd0);

    // Multiply: operands held through EXEC, result at MC+1 after acceptance
    push1(32'd7, 32'd6, 3'b010);
    tick;
    chk("mul_k1_a", alu_a, 32'd7);
    chk("mul_k1_b", alu_b, 32'd6);
    chk("mul_k1_op", {29'd0, alu_op}, 32'd2);
    for (int i = 2; i <= MC; i++) begin
      tick;
      chk("mul_hold_valid", {31'd0, rsp_valid}, 32'd0);
      chk("mul_hold_a", alu_a, 32'd7);
      chk("mul_hold_b", alu_b, 32'd6);
      chk("mul_hold_op", {29'd0, alu_op}, 32'd2);
    end
    tick;
    chk("mul_valid", {31'd0, rsp_valid}, 32'd1);
    chk("mul_data", rsp_data, 32'd42);
    chk("mul_op", {29'd0, rsp_op}, 32'd2);
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
    chk("mul_busy", {31'd0, busy}, 32'd0);

    // Backpressure: 5 accepted, 6th refused, then drain one per 2 cycles
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      req_valid = 1'b1;
      req_a     = 32'd10 + 32'(i);
      req_b     = 32'd1;
      req_op    = 3'b000;
      if (i == 5) chk("bp_6th_ready", {31'd0, req_ready}, 32'd0);
      if (req_ready) acc++;
      tick;
    end
    req_valid = 1'b0;
    chk("bp_accepted", 32'(acc), 32'd5);
    chk("bp_hold_data", rsp_data, 32'd11);
    rsp_ready = 1'b1;
    for (int j = 0; j < 5; j++) begin
      chk("bp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("bp_data", rsp_data, 32'd11 + 32'(j));
      tick;
      chk("bp_gap", {31'd0, rsp_valid}, 32'd0);
      tick;
    end
    rsp_ready = 1'b0;
    chk("bp_busy", {31'd0, busy}, 32'd0);

    // Reset during a multiply with two ops queued
    push1(32'd3, 32'd4, 3'b010);
    push1(32'd1, 32'd1, 3'b000);
    push1(32'd2, 32'd2, 3'b000);
    repeat (7) tick;
    RST = 1'b1;
    tick;
    RST = 1'b0;
    chk("rmid_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rmid_busy", {31'd0, busy}, 32'd0);
    chk("rmid_ready", {31'd0, req_ready}, 32'd1);
    chk("rmid_alu_a", alu_a, 32'd0);
    chk("rmid_alu_b", alu_b, 32'd0);
    chk("rmid_alu_op", {29'd0, alu_op}, 32'd0);
    rsp_ready = 1'b1;
    seen = 0;
    repeat (60) begin
      tick;
      if (rsp_valid) seen++;
    end
    rsp_ready = 1'b0;
    chk("rmid_no_rsp", 32'(seen), 32'd0);

    // Push and response handshake in the same cycle with one entry queued
    push1(32'd100, 32'd1, 3'b000);
    push1(32'd200, 32'd2, 3'b000);
    tick;
    chk("sim_first_valid", {31'd0, rsp_valid}, 32'd1);
    chk("sim_first_data", rsp_data, 32'd101);
    chk("sim_push_ready", {31'd0, req_ready}, 32'd1);
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    req_a     = 32'd300;
    req_b     = 32'd3;
    req_op    = 3'b000;
    tick;
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    chk("sim_exec_valid", {31'd0, rsp_valid}, 32'd0);
    chk("sim_exec_alu_a", alu_a, 32'd200);
    chk("sim_exec_busy", {31'd0, busy}, 32'd1);
    tick;
    chk("sim_second_valid", {31'd0, rsp_valid}, 32'd1);
    chk("sim_second_data", rsp_data, 32'd202);
    rsp_ready = 1'b1;
    tick;
    chk("sim_third_alu_a", alu_a, 32'd300);
    tick;
    chk("sim_third_valid", {31'd0, rsp_valid}, 32'd1);
    chk("sim_third_data", rsp_data, 32'd303);
    tick;
    chk("sim_end_valid", {31'd0, rsp_valid}, 32'd0);
    chk("sim_end_busy", {31'd0, busy}, 32'd0);
    seen = 0;
    repeat (10) begin
      tick;
      if (rsp_valid) seen++;
    end
    rsp_ready = 1'b0;
    chk("sim_no_dup", 32'(seen), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
